// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: fires on a time/alarm match, then handles ringing, bounded snooze and timeout.
// State and outputs move one clock after a trigger tick or a button edge; there is no backpressure.
module alarm_ring_ctrl #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int LED_W          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic [5:0]       hour,
    input  logic [5:0]       minute,
    input  logic [5:0]       second,
    input  logic [5:0]       alarm_hour,
    input  logic [5:0]       alarm_minute,
    input  logic             alarm_en,
    input  logic             stop,
    input  logic             snooze,
    output logic             ring,
    output logic [LED_W-1:0] ledr,
    output logic             snoozing,
    output logic [1:0]       snooze_left
);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    localparam logic [7:0] RING_LIM  = 8'(RING_SECONDS);
    localparam logic [9:0] SNZ_LIM   = 10'(SNOOZE_SECONDS);
    localparam logic [1:0] MAX_LEFT  = 2'(MAX_SNOOZE);

    state_t           state;
    logic             stop_q;
    logic             snooze_q;
    logic [7:0]       ring_cnt;
    logic [9:0]       snz_cnt;

    logic             stop_edge;
    logic             snooze_edge;
    logic             trigger;
    logic [7:0]       ring_inc;
    logic [9:0]       snz_inc;
    logic [LED_W-1:0] led_pat;

    assign stop_edge   = stop & ~stop_q;
    assign snooze_edge = snooze & ~snooze_q;
    assign trigger     = sec_tick && (hour == alarm_hour) && (minute == alarm_minute)
                         && (second == 6'd0);

    // Saturating increments keep the counters from wrapping.
    assign ring_inc = (ring_cnt == 8'hFF)  ? ring_cnt : ring_cnt + 8'd1;
    assign snz_inc  = (snz_cnt == 10'h3FF) ? snz_cnt  : snz_cnt + 10'd1;

    // Alternating pattern with the LSB clear: ...1010.
    always_comb begin
        led_pat = '0;
        for (int i = 0; i < LED_W; i++) begin
            led_pat[i] = ((i % 2) == 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            stop_q      <= 1'b0;
            snooze_q    <= 1'b0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            ring        <= 1'b0;
            ledr        <= '0;
            snoozing    <= 1'b0;
            snooze_left <= MAX_LEFT;
        end else begin
            stop_q   <= stop;
            snooze_q <= snooze;
            if (!alarm_en) begin
                state       <= IDLE;
                ring_cnt    <= '0;
                snz_cnt     <= '0;
                ring        <= 1'b0;
                ledr        <= '0;
                snoozing    <= 1'b0;
                snooze_left <= MAX_LEFT;
            end else begin
                case (state)
                    IDLE: begin
                        if (trigger && !stop_edge) begin
                            state       <= RINGING;
                            ring_cnt    <= '0;
                            ring        <= 1'b1;
                            ledr        <= led_pat;
                            snooze_left <= MAX_LEFT;
                        end
                    end
                    RINGING: begin
                        if (stop_edge) begin
                            state       <= IDLE;
                            ring_cnt    <= '0;
                            ring        <= 1'b0;
                            ledr        <= '0;
                            snooze_left <= MAX_LEFT;
                        end else if (snooze_edge && snooze_left != 2'd0) begin
                            state       <= SNOOZE;
                            snz_cnt     <= '0;
                            ring        <= 1'b0;
                            ledr        <= '0;
                            snoozing    <= 1'b1;
                            snooze_left <= snooze_left - 2'd1;
                        end else if (sec_tick) begin
                            if (ring_inc == RING_LIM) begin
                                state       <= IDLE;
                                ring_cnt    <= '0;
                                ring        <= 1'b0;
                                ledr        <= '0;
                                snooze_left <= MAX_LEFT;
                            end else begin
                                ring_cnt <= ring_inc;
                                ledr     <= ~ledr;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (stop_edge) begin
                            state       <= IDLE;
                            snz_cnt     <= '0;
                            snoozing    <= 1'b0;
                            snooze_left <= MAX_LEFT;
                        end else if (sec_tick) begin
                            if (snz_inc == SNZ_LIM) begin
                                state    <= RINGING;
                                ring_cnt <= '0;
                                ring     <= 1'b1;
                                ledr     <= led_pat;
                                snoozing <= 1'b0;
                            end else begin
                                snz_cnt <= snz_inc;
                            end
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        ring        <= 1'b0;
                        ledr        <= '0;
                        snoozing    <= 1'b0;
                        snooze_left <= MAX_LEFT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with short ring/snooze periods.
module tb_alarm_ring_ctrl;

    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          sec_tick;
    logic [5:0]    hour, minute, second, alarm_hour, alarm_minute;
    logic          alarm_en, stop, snooze;
    logic          ring;
    logic [LW-1:0] ledr;
    logic          snoozing;
    logic [1:0]    snooze_left;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alarm_ring_ctrl #(
        .RING_SECONDS  (4),
        .SNOOZE_SECONDS(3),
        .MAX_SNOOZE    (3),
        .LED_W         (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .alarm_hour  (alarm_hour),
        .alarm_minute(alarm_minute),
        .alarm_en    (alarm_en),
        .stop        (stop),
        .snooze      (snooze),
        .ring        (ring),
        .ledr        (ledr),
        .snoozing    (snoozing),
        .snooze_left (snooze_left)
    );

    typedef struct {
        logic          tick;
        logic [5:0]    h, m, s, ah, am;
        logic          en, stp, snz;
        logic          e_ring;
        logic [LW-1:0] e_led;
        logic          e_snz;
        logic [1:0]    e_left;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic tick, input int h, input int m, input int s,
                               input int ah, input int am, input logic en, input logic stp,
                               input logic snz, input logic e_ring, input logic [LW-1:0] e_led,
                               input logic e_snz, input int e_left);
        vec_t r;
        r.tick = tick; r.h = 6'(h); r.m = 6'(m); r.s = 6'(s);
        r.ah = 6'(ah); r.am = 6'(am); r.en = en; r.stp = stp; r.snz = snz;
        r.e_ring = e_ring; r.e_led = e_led; r.e_snz = e_snz; r.e_left = 2'(e_left);
        return r;
    endfunction

    task automatic check(input string name, input logic e_ring, input logic [LW-1:0] e_led,
                         input logic e_snz, input logic [1:0] e_left);
        checks++;
        if (ring !== e_ring || ledr !== e_led || snoozing !== e_snz || snooze_left !== e_left) begin
            failures++;
            $display("FAIL %s: got ring=%b ledr=%h snoozing=%b left=%0d, expected ring=%b ledr=%h snoozing=%b left=%0d",
                     name, ring, ledr, snoozing, snooze_left, e_ring, e_led, e_snz, e_left);
        end
    endtask

    task automatic drive(input vec_t x);
        sec_tick = x.tick; hour = x.h; minute = x.m; second = x.s;
        alarm_hour = x.ah; alarm_minute = x.am; alarm_en = x.en; stop = x.stp; snooze = x.snz;
    endtask

    initial begin
        rst = 1'b1; sec_tick = 0; hour = 7; minute = 29; second = 59;
        alarm_hour = 7; alarm_minute = 30; alarm_en = 1; stop = 0; snooze = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 10'h000, 1'b0, 2'd3);
        rst = 1'b0;

        // Trigger, toggle and 4-tick timeout.
        vq.push_back(v(1, 7,30,0, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(0, 7,30,0, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(1, 7,30,1, 7,30, 1,0,0, 1,10'h155,0,3));
        vq.push_back(v(1, 7,30,2, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(1, 7,30,3, 7,30, 1,0,0, 1,10'h155,0,3));
        vq.push_back(v(1, 7,30,4, 7,30, 1,0,0, 0,10'h000,0,3));
        vq.push_back(v(1, 7,30,5, 7,30, 1,0,0, 0,10'h000,0,3));
        // Snooze and re-ring after 3 ticks.
        vq.push_back(v(1, 7,30,0, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(0, 7,30,0, 7,30, 1,0,1, 0,10'h000,1,2));
        vq.push_back(v(1, 7,30,1, 7,30, 1,0,1, 0,10'h000,1,2));
        vq.push_back(v(1, 7,30,2, 7,30, 1,0,0, 0,10'h000,1,2));
        vq.push_back(v(1, 7,30,3, 7,30, 1,0,0, 1,10'h2AA,0,2));
        // Exhaust snoozes; the fourth is ignored; stop ends the event.
        vq.push_back(v(0, 7,30,3, 7,30, 1,0,1, 0,10'h000,1,1));
        vq.push_back(v(0, 7,30,3, 7,30, 1,0,0, 0,10'h000,1,1));
        vq.push_back(v(1, 7,30,4, 7,30, 1,0,0, 0,10'h000,1,1));
        vq.push_back(v(1, 7,30,5, 7,30, 1,0,0, 0,10'h000,1,1));
        vq.push_back(v(1, 7,30,6, 7,30, 1,0,0, 1,10'h2AA,0,1));
        vq.push_back(v(0, 7,30,6, 7,30, 1,0,1, 0,10'h000,1,0));
        vq.push_back(v(0, 7,30,6, 7,30, 1,0,0, 0,10'h000,1,0));
        vq.push_back(v(1, 7,30,7, 7,30, 1,0,0, 0,10'h000,1,0));
        vq.push_back(v(1, 7,30,8, 7,30, 1,0,0, 0,10'h000,1,0));
        vq.push_back(v(1, 7,30,9, 7,30, 1,0,0, 1,10'h2AA,0,0));
        vq.push_back(v(0, 7,30,9, 7,30, 1,0,1, 1,10'h2AA,0,0));
        vq.push_back(v(0, 7,30,9, 7,30, 1,0,0, 1,10'h2AA,0,0));
        vq.push_back(v(0, 7,30,9, 7,30, 1,1,0, 0,10'h000,0,3));
        vq.push_back(v(0, 7,30,9, 7,30, 1,0,0, 0,10'h000,0,3));
        // alarm_en drop in SNOOZE; stop+snooze together.
        vq.push_back(v(1, 7,30,0, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(0, 7,30,0, 7,30, 1,0,1, 0,10'h000,1,2));
        vq.push_back(v(0, 7,30,0, 7,30, 0,0,0, 0,10'h000,0,3));
        vq.push_back(v(1, 7,30,0, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(0, 7,30,0, 7,30, 1,1,1, 0,10'h000,0,3));
        vq.push_back(v(0, 7,30,0, 7,30, 1,0,0, 0,10'h000,0,3));
        // Snooze edge on the expiry tick wins; trigger ignored while snoozing.
        vq.push_back(v(1, 7,30,0, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(1, 7,30,1, 7,30, 1,0,0, 1,10'h155,0,3));
        vq.push_back(v(1, 7,30,2, 7,30, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(1, 7,30,3, 7,30, 1,0,0, 1,10'h155,0,3));
        vq.push_back(v(1, 7,30,4, 7,30, 1,0,1, 0,10'h000,1,2));
        vq.push_back(v(1, 7,30,0, 7,30, 1,0,0, 0,10'h000,1,2));
        vq.push_back(v(0, 7,30,0, 7,30, 1,1,0, 0,10'h000,0,3));
        vq.push_back(v(0, 7,30,0, 7,30, 1,0,0, 0,10'h000,0,3));
        // Midnight wrap with alarm 00:00; alarm change mid-ring has no effect.
        vq.push_back(v(1, 23,59,59, 0,0, 1,0,0, 0,10'h000,0,3));
        vq.push_back(v(1, 0,0,0,    0,0, 1,0,0, 1,10'h2AA,0,3));
        vq.push_back(v(1, 0,0,1,   12,0, 1,0,0, 1,10'h155,0,3));

        foreach (vq[i]) begin
            drive(vq[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vq[i].e_ring, vq[i].e_led, vq[i].e_snz, vq[i].e_left);
        end

        // Reset while ringing returns everything to reset values.
        sec_tick = 1; hour = 0; minute = 0; second = 2; rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ring", 1'b0, 10'h000, 1'b0, 2'd3);
        rst = 1'b0; sec_tick = 0;
        @(posedge clk);
        #1;
        check("after_rst_idle", 1'b0, 10'h000, 1'b0, 2'd3);

        // Stop edge does not change outputs until the following clock.
        hour = 7; minute = 30; second = 0; alarm_hour = 7; alarm_minute = 30; sec_tick = 1;
        @(posedge clk);
        #1;
        sec_tick = 0;
        check("retrigger", 1'b1, 10'h2AA, 1'b0, 2'd3);
        stop = 1;
        #2;
        check("stop_pre_clock", 1'b1, 10'h2AA, 1'b0, 2'd3);
        @(posedge clk);
        #1;
        check("stop_post_clock", 1'b0, 10'h000, 1'b0, 2'd3);
        // Held stop gives no new edge, so a fresh trigger still rings.
        sec_tick = 1;
        @(posedge clk);
        #1;
        sec_tick = 0;
        check("held_stop_no_edge", 1'b1, 10'h2AA, 1'b0, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
